// File: rtl/glyph_pkg.sv
// Shared constants and state type for the glyph pixel generator.
// GLYPH_SPACING_EN adds one all-background spacing column to every cell.
package glyph_pkg;
  localparam int GLYPH_COLS = 5;
  localparam int GLYPH_ROWS = 8;
`ifdef GLYPH_SPACING_EN
  localparam int SPACING_COLS = 1;
`else
  localparam int SPACING_COLS = 0;
`endif
  localparam int CELL_COLS = GLYPH_COLS + SPACING_COLS;
  localparam int FONT_AW   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } glyph_state_e;
endpackage

// File: rtl/glyph_pixel_gen.sv
// Renders one character cell: fetches the font columns from an external ROM,
// then streams the cell's pixels row-major. Build option: GLYPH_SPACING_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid and its payload are held until that edge, and ready never depends
// on the same-cycle valid of the opposite side.
module glyph_pixel_gen #(
  parameter int PIX_W      = 16,
  parameter int GLYPH_COLS = glyph_pkg::GLYPH_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic [7:0]       char_code,
  input  logic [PIX_W-1:0] fg_color,
  input  logic [PIX_W-1:0] bg_color,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_last,
  output logic             busy
);
  import glyph_pkg::*;

  localparam int          CELL_N     = GLYPH_COLS + SPACING_COLS;
  localparam logic [2:0]  LAST_FETCH = 3'(GLYPH_COLS);
  localparam logic [2:0]  LAST_COL   = 3'(CELL_N - 1);
  localparam logic [2:0]  LAST_ROW   = 3'(GLYPH_ROWS - 1);
  localparam logic [2:0]  FONT_COLS  = 3'(GLYPH_COLS);

  glyph_state_e       state, state_nxt;
  logic               alive;
  logic [2:0]         fetch_cnt;
  logic [2:0]         row_cnt;
  logic [2:0]         col_cnt;
  logic [PIX_W-1:0]   fg_q, bg_q;
  logic [7:0]         col_buf [GLYPH_COLS];
  logic [7:0]         col_byte;
  logic [FONT_AW-1:0] base_addr;
  logic               accept;
  logic               pix_fire;

  assign base_addr  = FONT_AW'(char_code) * FONT_AW'(GLYPH_COLS);
  assign char_ready = alive && (state == ST_IDLE);
  assign accept     = char_valid && char_ready;
  assign busy       = (state != ST_IDLE);
  assign pix_valid  = (state == ST_EMIT);
  assign pix_last   = pix_valid && (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
  assign pix_fire   = pix_valid && pix_ready;

  // Spacing column (index >= GLYPH_COLS) reads as an empty font byte.
  always_comb begin
    col_byte = 8'h00;
    if (col_cnt < FONT_COLS) col_byte = col_buf[col_cnt];
  end

  always_comb begin
    pix_data = '0;
    if (pix_valid) pix_data = col_byte[row_cnt] ? fg_q : bg_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_FETCH;
      ST_FETCH: if (fetch_cnt == LAST_FETCH) state_nxt = ST_EMIT;
      ST_EMIT:  if (pix_fire && pix_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // alive keeps char_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      alive     <= 1'b0;
      font_addr <= '0;
      fetch_cnt <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      for (int i = 0; i < GLYPH_COLS; i++) col_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fg_q      <= fg_color;
            bg_q      <= bg_color;
            font_addr <= base_addr;
            fetch_cnt <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
          end
        end
        ST_FETCH: begin
          // ROM data lags the address by one cycle, so column k lands at count k+1.
          fetch_cnt <= fetch_cnt + 3'd1;
          if (fetch_cnt != 3'd0) col_buf[fetch_cnt - 3'd1] <= font_data;
          if (fetch_cnt < LAST_FETCH - 3'd1) font_addr <= font_addr + 11'd1;
        end
        ST_EMIT: begin
          if (pix_fire) begin
            if (col_cnt == LAST_COL) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 3'd1;
            end else begin
              col_cnt <= col_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_glyph_pixel_gen.sv
// Self-checking bench for glyph_pixel_gen: random font ROM, reference cell
// renderer, scoreboard of expected pixels.
module tb_glyph_pixel_gen;
  localparam int PIX_W = 16;
`ifdef GLYPH_SPACING_EN
  localparam int CELL_COLS = 6;
`else
  localparam int CELL_COLS = 5;
`endif
  localparam int NPIX = 8 * CELL_COLS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             char_valid = 1'b0;
  logic             char_ready;
  logic [7:0]       char_code = '0;
  logic [PIX_W-1:0] fg_color = '0;
  logic [PIX_W-1:0] bg_color = '0;
  logic [10:0]      font_addr;
  logic [7:0]       font_data;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             busy;

  logic [7:0]       rom [0:2047];
  logic [PIX_W-1:0] exp_q[$];
  logic [PIX_W-1:0] got_q[$];
  int errors = 0;
  int checks = 0;

  glyph_pixel_gen #(.PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_ready(char_ready),
    .char_code(char_code), .fg_color(fg_color), .bg_color(bg_color),
    .font_addr(font_addr), .font_data(font_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last), .busy(busy)
  );

  // clock / reset block and font ROM with one cycle read latency
  always #5 clk = ~clk;
  always @(posedge clk) font_data <= rom[font_addr];

  // reference: pixel (r,c) is fg when bit r of font byte code*5+c is set
  task automatic build_expected(input int code, input logic [PIX_W-1:0] fg,
                                input logic [PIX_W-1:0] bg);
    exp_q.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < CELL_COLS; c++) begin
        logic [7:0] b;
        b = (c < 5) ? rom[code * 5 + c] : 8'h00;
        exp_q.push_back(b[r] ? fg : bg);
      end
  endtask

  // driver: present one character at a negedge, wait for its acceptance
  task automatic send_char(input logic [7:0] code, input logic [PIX_W-1:0] fg,
                           input logic [PIX_W-1:0] bg);
    int n = 0;
    while (char_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: char_ready=%b required 1", char_ready);
    end
    char_valid = 1'b1;
    char_code  = code;
    fg_color   = fg;
    bg_color   = bg;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic check_fetch_addrs(input int base);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (font_addr !== 11'(base + k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL fetch_addr k=%0d: font_addr=%0d busy=%b required %0d busy=1",
                 k, font_addr, busy, base + k);
      end
      @(negedge clk);
    end
  endtask

  // monitor + scoreboard: take n_take pixels, checking order, pix_last and hold
  task automatic collect(input int n_take, input bit rand_ready, input int stall_at,
                         input bit noise);
    int got = 0;
    int cyc = 0;
    int stall_left = (stall_at >= 0) ? 10 : 0;
    logic prev_stall = 1'b0;
    logic [PIX_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    got_q.delete();
    while (got < n_take && cyc < 3000) begin
      logic hs;
      if (prev_stall) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== prev_data || pix_last !== prev_last) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h last=%b required 1 %h %b",
                   pix_valid, pix_data, pix_last, prev_data, prev_last);
        end
      end
      if (got == stall_at && stall_left > 0 && pix_valid === 1'b1) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      hs = (pix_valid === 1'b1 && pix_ready === 1'b1);
      char_valid = (noise && !(hs && got == n_take - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        char_code = 8'($urandom);
        fg_color  = PIX_W'($urandom);
        bg_color  = PIX_W'($urandom);
      end
      if (hs) begin
        logic [PIX_W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel: data=%h required no pixel", pix_data);
        end else begin
          e = exp_q.pop_front();
          if (pix_data !== e) begin
            errors++;
            $display("FAIL pixel %0d: data=%h required %h", got, pix_data, e);
          end
        end
        checks++;
        if (pix_last !== (got == NPIX - 1)) begin
          errors++;
          $display("FAIL pix_last %0d: last=%b required %b", got, pix_last, got == NPIX - 1);
        end
        got_q.push_back(pix_data);
        got++;
      end
      prev_stall = (pix_valid === 1'b1 && pix_ready === 1'b0);
      prev_data  = pix_data;
      prev_last  = pix_last;
      @(negedge clk);
      cyc++;
    end
    char_valid = 1'b0;
    pix_ready  = 1'b0;
    checks++;
    if (got != n_take) begin
      errors++;
      $display("FAIL pixel_count: got=%0d required %0d", got, n_take);
    end
    if (n_take == NPIX) begin
      checks++;
      if (char_ready !== 1'b1 || pix_valid !== 1'b0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL cell_end: char_ready=%b pix_valid=%b left=%0d required 1 0 0",
                 char_ready, pix_valid, exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (char_ready !== 1'b0 || pix_valid !== 1'b0 || pix_last !== 1'b0 ||
        pix_data !== '0 || font_addr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b pv=%b pl=%b pd=%h fa=%h busy=%b required all 0",
               char_ready, pix_valid, pix_last, pix_data, font_addr, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: char_ready=%b busy=%b required 1 0", char_ready, busy);
    end
  endtask

  task automatic test_letter_a();
    logic [PIX_W-1:0] fg = 16'hF800;
    logic [PIX_W-1:0] bg = 16'h001F;
    build_expected(8'h41, fg, bg);
    send_char(8'h41, fg, bg);
    check_fetch_addrs(11'h145);
    collect(NPIX, 1'b0, -1, 1'b0);
    checks++;
    if (got_q.size() != NPIX || got_q[0] !== bg || got_q[1] !== bg || got_q[2] !== fg ||
        got_q[3] !== bg || got_q[4] !== bg) begin
      errors++;
      $display("FAIL letter_a_row0: size=%0d required bg,bg,fg,bg,bg", got_q.size());
    end
    for (int c = 0; c < CELL_COLS; c++) begin
      checks++;
      if (got_q.size() != NPIX || got_q[7 * CELL_COLS + c] !== bg) begin
        errors++;
        $display("FAIL letter_a_row7 col=%0d: required bg %h", c, bg);
      end
    end
  endtask

  task automatic test_max_code();
    build_expected(255, 16'h07E0, 16'h0000);
    send_char(8'hFF, 16'h07E0, 16'h0000);
    check_fetch_addrs(1275);
    collect(NPIX, 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [7:0] code = 8'($urandom);
    build_expected(code, 16'hFFFF, 16'h1234);
    send_char(code, 16'hFFFF, 16'h1234);
    collect(NPIX, 1'b0, 13, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] code = 8'($urandom);
      logic [PIX_W-1:0] fg = PIX_W'($urandom);
      logic [PIX_W-1:0] bg = ~fg;
      build_expected(code, fg, bg);
      send_char(code, fg, bg);
      collect(NPIX, 1'b0, -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [7:0] code = 8'($urandom);
    build_expected(code, 16'hAAAA, 16'h5555);
    send_char(code, 16'hAAAA, 16'h5555);
    collect(17, 1'b0, -1, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_data !== '0 ||
        char_ready !== 1'b0 || busy !== 1'b0 || font_addr !== '0) begin
      errors++;
      $display("FAIL reset_abort: pv=%b pl=%b pd=%h rdy=%b busy=%b fa=%h required all 0",
               pix_valid, pix_last, pix_data, char_ready, busy, font_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: char_ready=%b pix_valid=%b required 1 0",
               char_ready, pix_valid);
    end
    code = 8'($urandom);
    build_expected(code, 16'h0F0F, 16'hF0F0);
    send_char(code, 16'h0F0F, 16'hF0F0);
    collect(NPIX, 1'b0, -1, 1'b0);
  endtask

  task automatic test_ignore_char_valid();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] code = 8'($urandom);
      logic [PIX_W-1:0] fg = PIX_W'($urandom);
      logic [PIX_W-1:0] bg = PIX_W'($urandom);
      build_expected(code, fg, bg);
      send_char(code, fg, bg);
      collect(NPIX, 1'b1, -1, 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h145] = 8'h7C;
    rom[11'h146] = 8'h12;
    rom[11'h147] = 8'h11;
    rom[11'h148] = 8'h12;
    rom[11'h149] = 8'h7C;
    test_reset();
    test_letter_a();
    test_max_code();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    test_ignore_char_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/glyph_pixel_gen.md
GLYPH_PIXEL_GEN -- requirements
Module: glyph_pixel_gen

Interface
REQ-001 Parameter: PIX_W, default 16, pixel colour width (RGB565).
REQ-002 Parameter: GLYPH_COLS, default 5, font columns per glyph; 1 font byte per column, bit r = row r, LSB = top row.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 char_valid  input  1  character request valid.
REQ-007 char_ready  output  1  block can accept a character.
REQ-008 char_code  input  8  character code.
REQ-009 fg_color  input  PIX_W  foreground colour, sampled with char_code.
REQ-010 bg_color  input  PIX_W  background colour, sampled with char_code.
REQ-011 font_addr  output  11  font ROM read address; registered output.
REQ-012 font_data  input  8  font ROM data; valid one cycle after font_addr is presented.
REQ-013 pix_valid  output  1  pixel valid.
REQ-014 pix_ready  input  1  downstream accepts pixel.
REQ-015 pix_data  output  PIX_W  pixel colour.
REQ-016 pix_last  output  1  final pixel of the cell.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement states IDLE, FETCH and EMIT.
REQ-019 char_ready SHALL be high only in IDLE; char_valid&&char_ready SHALL latch char_code, fg_color and bg_color and move to FETCH.
REQ-020 FETCH SHALL drive font_addr = char_code*5 + k for k = 0..4 on consecutive cycles, using 11-bit unsigned arithmetic (max 1279, no overflow).
REQ-021 FETCH SHALL capture font_data for column k the cycle after address k is driven, and SHALL enter EMIT after column 4 is captured (FETCH lasts 6 cycles).
REQ-022 EMIT SHALL output pixels row-major: row 0..7, column 0..CELL_COLS-1.
REQ-023 pix_data SHALL be fg_color when bit row of column byte col is 1, otherwise bg_color.
REQ-024 pix_data, pix_valid and pix_last SHALL hold stable while pix_valid && !pix_ready.
REQ-025 The pixel counter SHALL advance only on pix_valid && pix_ready.
REQ-026 pix_last SHALL be high only for row 7, column CELL_COLS-1.
REQ-027 On the pix_last handshake the block SHALL return to IDLE, with char_ready high the following cycle.
REQ-028 char_valid asserted outside IDLE SHALL be ignored, with no latching.
REQ-029 Colour inputs changing mid-cell SHALL NOT affect the cell in progress.

Reset
REQ-030 While rst is high: state = IDLE, char_ready = 0, pix_valid = 0, pix_last = 0, pix_data = 0, font_addr = 0, busy = 0, column buffer and counters = 0.
REQ-031 Reset asserted mid-FETCH or mid-EMIT SHALL abort the cell; no further pixels are emitted for it.
REQ-032 char_ready SHALL rise the first cycle after rst deasserts.

Configuration
REQ-033 Macro GLYPH_SPACING_EN defined: CELL_COLS = 6; column 5 is an all-background spacing column; 48 pixels per cell.
REQ-034 Macro GLYPH_SPACING_EN undefined: CELL_COLS = 5; 40 pixels per cell; no spacing column.

Structure
REQ-035 Package glyph_pkg SHALL hold GLYPH_COLS, GLYPH_ROWS = 8, CELL_COLS (macro-dependent), the state enum and the font address width (11).
REQ-036 The design SHALL be a single module with no sub-module; the 5x8 column buffer and counters are local.

Verification
REQ-037 Accept char_code 0x41; font model returns 7C,12,11,12,7C -> font_addr 0x145..0x149 on consecutive cycles; row 0 = bg,bg,fg,bg,bg; row 7 all bg.
REQ-038 char_code 0xFF -> font_addr 1275..1279 with no wrap.
REQ-039 pix_ready held low 10 cycles mid-row -> pix_data and pix_valid stable; no pixel lost or duplicated; total pixels = 40, or 48 with GLYPH_SPACING_EN.
REQ-040 Back-to-back chars with pix_ready = 1 -> pix_last on pixel 40 or 48; char_ready high exactly 1 cycle after it; second char latched.
REQ-041 rst pulse during EMIT at pixel 17 -> pix_valid = 0 immediately; char_ready = 1 after release; next char renders from row 0.
REQ-042 char_valid toggled during FETCH/EMIT with changed fg_color -> ignored; current cell colours unchanged.
